// File: rtl/spi_reg_bank.sv
// SPI register bank: decodes spi_slave byte stream into NUM_REGS byte registers with burst auto-increment.
// Optional idle-byte timeout is built when SPI_REG_BANK_TIMEOUT_EN is defined.
module spi_reg_bank #(
  parameter int                    NUM_REGS       = 8,
  parameter logic [7:0]            FPGA_VER       = 8'hC2,
  parameter logic [NUM_REGS-1:0]   RW_MASK        = NUM_REGS'(2),
  parameter logic [NUM_REGS*8-1:0] RESET_VAL      = '0,
  parameter int                    TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk_core,
  input  logic                    reset_n,
  input  logic                    transaction_begin,
  input  logic                    rx_byte_available,
  input  logic [7:0]              rx_byte,
  output logic [7:0]              tx_byte,
  input  logic [NUM_REGS*8-1:0]   reg_in,
  output logic [NUM_REGS*8-1:0]   reg_out,
  output logic [NUM_REGS-1:0]     wr_strobe,
  output logic                    busy,
  output logic                    timeout_pulse
);

  if (NUM_REGS < 2 || NUM_REGS > 128 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_reg_bank: parameter out of range");
  end

  // Register 0 is the version register and can never be written.
  localparam logic [NUM_REGS-1:0] RW_EFF = RW_MASK & ~NUM_REGS'(1);

  function automatic logic [NUM_REGS*8-1:0] byte_mask(input logic [NUM_REGS-1:0] m);
    byte_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      byte_mask[8*i +: 8] = {8{m[i]}};
    end
  endfunction

  localparam logic [NUM_REGS*8-1:0] RST_EFF = RESET_VAL & byte_mask(RW_EFF);

  function automatic logic [7:0] rd_byte(input logic [6:0]            a,
                                         input logic [NUM_REGS*8-1:0] rw_val,
                                         input logic [NUM_REGS*8-1:0] ro_val);
    rd_byte = 8'h00;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (int'(a) == i) rd_byte = RW_EFF[i] ? rw_val[8*i +: 8] : ro_val[8*i +: 8];
    end
    if (a == 7'd0) rd_byte = FPGA_VER;
  endfunction

  function automatic logic [6:0] next_addr(input logic [6:0] a);
    if (int'(a) == NUM_REGS - 1) next_addr = 7'd0;
    else                         next_addr = a + 7'd1;
  endfunction

  typedef enum logic [1:0] {IDLE, CMD, READ, WRITE} state_t;

  state_t     state;
  logic [6:0] addr;
  logic       rxa_p0, rxa_p1, rxa_p2;
  logic       byte_vld_p2;

  // Stage p0/p1: two-flop synchroniser; stage p2: previous value for edge detection.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      rxa_p0 <= 1'b0;
      rxa_p1 <= 1'b0;
      rxa_p2 <= 1'b0;
    end else begin
      rxa_p0 <= rx_byte_available;
      rxa_p1 <= rxa_p0;
      rxa_p2 <= rxa_p1;
    end
  end

  // rx_byte has been stable for several cycles by the time this fires, so it is sampled directly.
  assign byte_vld_p2 = rxa_p1 & ~rxa_p2;
  assign busy        = (state != IDLE);

`ifdef SPI_REG_BANK_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_pulse = 1'b0;
`endif

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tx_byte   <= 8'h00;
      wr_strobe <= '0;
      reg_out   <= RST_EFF;
      addr      <= 7'd0;
`ifdef SPI_REG_BANK_TIMEOUT_EN
      tmo_cnt       <= '0;
      timeout_pulse <= 1'b0;
`endif
    end else begin
      wr_strobe <= '0;
`ifdef SPI_REG_BANK_TIMEOUT_EN
      timeout_pulse <= 1'b0;
      if (transaction_begin || byte_vld_p2 || state == IDLE || tmo_hit) tmo_cnt <= '0;
      else                                                             tmo_cnt <= tmo_cnt + 32'd1;
`endif
      if (transaction_begin) begin
        state   <= CMD;
        tx_byte <= 8'h00;
      end else if (byte_vld_p2) begin
        case (state)
          IDLE: ;
          CMD: begin
            if (rx_byte[7]) begin
              state <= WRITE;
              addr  <= rx_byte[6:0];
            end else begin
              // Preload the start register so the first data slot returns it.
              state   <= READ;
              tx_byte <= rd_byte(rx_byte[6:0], reg_out, reg_in);
              addr    <= next_addr(rx_byte[6:0]);
            end
          end
          READ: begin
            tx_byte <= rd_byte(addr, reg_out, reg_in);
            addr    <= next_addr(addr);
          end
          WRITE: begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (int'(addr) == i && RW_EFF[i]) begin
                reg_out[8*i +: 8] <= rx_byte;
                wr_strobe[i]      <= 1'b1;
              end
            end
            addr <= next_addr(addr);
          end
          default: state <= IDLE;
        endcase
`ifdef SPI_REG_BANK_TIMEOUT_EN
      end else if (tmo_hit && state != IDLE) begin
        state         <= IDLE;
        tx_byte       <= 8'h00;
        timeout_pulse <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed self-checking bench for spi_reg_bank (NUM_REGS=8, RW_MASK=8'h06, TIMEOUT_CYCLES=100).
module tb_spi_reg_bank;

  localparam logic [63:0] RST_VAL = 64'h0000_0000_4433_00EE;
  localparam logic [63:0] EXP_RST = 64'h0000_0000_0033_0000;
  localparam logic [63:0] EXP_BW  = 64'h0000_0000_003C_A500;

  logic        clk_core;
  logic        reset_n;
  logic        transaction_begin;
  logic        rx_byte_available;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic [63:0] reg_in;
  logic [63:0] reg_out;
  logic [7:0]  wr_strobe;
  logic        busy;
  logic        timeout_pulse;

  int tests = 0;
  int fails = 0;

  spi_reg_bank #(
    .NUM_REGS      (8),
    .FPGA_VER      (8'hC2),
    .RW_MASK       (8'h06),
    .RESET_VAL     (RST_VAL),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_core         (clk_core),
    .reset_n          (reset_n),
    .transaction_begin(transaction_begin),
    .rx_byte_available(rx_byte_available),
    .rx_byte          (rx_byte),
    .tx_byte          (tx_byte),
    .reg_in           (reg_in),
    .reg_out          (reg_out),
    .wr_strobe        (wr_strobe),
    .busy             (busy),
    .timeout_pulse    (timeout_pulse)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic begin_txn();
    transaction_begin = 1'b1;
    tick();
    transaction_begin = 1'b0;
  endtask

  // After this returns the byte event has been processed by the DUT.
  task automatic rise(input logic [7:0] b);
    rx_byte           = b;
    rx_byte_available = 1'b1;
    repeat (3) tick();
  endtask

  task automatic fall();
    rx_byte_available = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rise(b);
    fall();
  endtask

  initial begin
    int n;
    logic seen;
    transaction_begin = 1'b0;
    rx_byte_available = 1'b0;
    rx_byte           = 8'h00;
    reg_in            = 64'h5A00_0000_9900_0000;
    reset_n           = 1'b1;
    #3 reset_n = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_tx",      64'(tx_byte),       64'h00);
    chk("rst_busy",    64'(busy),          64'h0);
    chk("rst_strobe",  64'(wr_strobe),     64'h00);
    chk("rst_tmo",     64'(timeout_pulse), 64'h0);
    chk("rst_reg_out", reg_out,            EXP_RST);
    reset_n = 1'b1;
    tick();

    // Version read
    begin_txn();
    chk("ver_busy", 64'(busy),    64'h1);
    chk("ver_tx0",  64'(tx_byte), 64'h00);
    rise(8'h00);
    chk("ver_tx",   64'(tx_byte), 64'hC2);
    fall();
    rise(8'hFF);
    chk("ver_rd1",  64'(tx_byte), 64'h00);
    fall();

    // Burst write
    begin_txn();
    rise(8'h81);
    chk("bw_cmd_tx", 64'(tx_byte), 64'h00);
    fall();
    rise(8'hA5);
    chk("bw_strobe1", 64'(wr_strobe), 64'h02);
    chk("bw_reg1",    64'(reg_out[15:8]), 64'hA5);
    fall();
    chk("bw_strobe1_off", 64'(wr_strobe), 64'h00);
    rise(8'h3C);
    chk("bw_strobe2", 64'(wr_strobe), 64'h04);
    chk("bw_reg2",    64'(reg_out[23:16]), 64'h3C);
    fall();
    rise(8'h77);
    chk("bw_strobe3", 64'(wr_strobe), 64'h00);
    chk("bw_reg_out", reg_out, EXP_BW);
    fall();

    // Wrap read from the last register
    begin_txn();
    rise(8'h07);
    chk("wrap_r7", 64'(tx_byte), 64'h5A);
    fall();
    send(8'h00);
    chk("wrap_r0", 64'(tx_byte), 64'hC2);
    send(8'h00);
    chk("wrap_r1", 64'(tx_byte), 64'hA5);
    send(8'h00);
    chk("wrap_r2", 64'(tx_byte), 64'h3C);

    // Read-only register returns status input
    begin_txn();
    send(8'h03);
    chk("ro_r3", 64'(tx_byte), 64'h99);

    // Out-of-range write and read
    begin_txn();
    send(8'h90);
    rise(8'h11);
    chk("oor_strobe",  64'(wr_strobe), 64'h00);
    chk("oor_reg_out", reg_out, EXP_BW);
    fall();
    begin_txn();
    send(8'h10);
    chk("oor_rd", 64'(tx_byte), 64'h00);
    begin_txn();
    send(8'h7F);
    chk("oor_r127", 64'(tx_byte), 64'h00);
    send(8'h00);
    chk("oor_wrap127", 64'(tx_byte), 64'hC2);

    // transaction_begin coincident with a byte event
    begin_txn();
    send(8'h81);
    rx_byte           = 8'h55;
    rx_byte_available = 1'b1;
    tick();
    tick();
    transaction_begin = 1'b1;
    tick();
    transaction_begin = 1'b0;
    chk("prio_tx",     64'(tx_byte), 64'h00);
    chk("prio_strobe", 64'(wr_strobe), 64'h00);
    chk("prio_reg1",   64'(reg_out[15:8]), 64'hA5);
    chk("prio_busy",   64'(busy), 64'h1);
    fall();
    send(8'h02);
    chk("prio_cmd_rd2", 64'(tx_byte), 64'h3C);

    // Asynchronous reset in the middle of a write burst
    begin_txn();
    send(8'h82);
    rise(8'h12);
    chk("mid_reg2", 64'(reg_out[23:16]), 64'h12);
    fall();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_reg_out", reg_out, EXP_RST);
    chk("mid_rst_busy",    64'(busy), 64'h0);
    chk("mid_rst_tx",      64'(tx_byte), 64'h00);
    tick();
    reset_n = 1'b1;
    tick();

    // Idle-byte timeout
    begin_txn();
    rise(8'h00);
    chk("tmo_ver", 64'(tx_byte), 64'hC2);
    fall();
`ifdef SPI_REG_BANK_TIMEOUT_EN
    n = 0;
    while (!timeout_pulse && n < 200) begin
      tick();
      n++;
    end
    chk("tmo_cycle", 64'(3 + n), 64'd100);
    chk("tmo_busy",  64'(busy), 64'h0);
    chk("tmo_tx",    64'(tx_byte), 64'h00);
    tick();
    chk("tmo_pulse_off", 64'(timeout_pulse), 64'h0);
`else
    seen = 1'b0;
    repeat (150) begin
      tick();
      if (timeout_pulse) seen = 1'b1;
    end
    chk("notmo_pulse", 64'(seen), 64'h0);
    chk("notmo_busy",  64'(busy), 64'h1);
    chk("notmo_tx",    64'(tx_byte), 64'hC2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Parametrised SPI register bank that replaces hand-coded per-register SPI decode in the top level.
- Sits between `spi_slave` (consumes `rx_byte_available`, `rx_byte` and `transaction_begin`; drives `tx_byte`) and fabric logic.
- Provides NUM_REGS 8-bit registers, each either read-only (status input) or read/write (control output).
- Supports burst reads/writes with address auto-increment and wrap-around.

Parameters:
- NUM_REGS, 8, number of registers; legal range 2..128.
- FPGA_VER, 8'hC2, value returned by register 0, which is always read-only.
- RW_MASK, {NUM_REGS{1'b0}} | 'h2, per-register bit; 1 = read/write, 0 = read-only. Bit 0 is ignored (forced read-only).
- RESET_VAL, {NUM_REGS*8{1'b0}}, reset contents of the read/write registers; byte i is reg i.
- TIMEOUT_CYCLES, 1000000, idle-byte timeout in clk_core cycles; used only with the optional feature.

Ports:
- clk_core  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset; deassertion is already synchronised to clk_core
- transaction_begin  in  1  one-cycle pulse from spi_slave at SS assertion
- rx_byte_available  in  1  level from spi_slave, asynchronous to clk_core; its rising edge marks a new rx_byte
- rx_byte  in  8  received byte; stable while rx_byte_available is high
- tx_byte  out  8  byte spi_slave shifts out on the next byte slot
- reg_in  in  NUM_REGS*8  status values returned for read-only regs 1..NUM_REGS-1; byte 0 unused
- reg_out  out  NUM_REGS*8  current contents of read/write regs; bytes of read-only regs read as 0
- wr_strobe  out  NUM_REGS  one-cycle pulse per register written
- busy  out  1  high when state != IDLE
- timeout_pulse  out  1  one-cycle pulse on transaction abort; constant 0 without the optional feature

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; tx_byte=0; wr_strobe=0; busy=0; timeout_pulse=0.
  - reg_out = RESET_VAL masked by RW_MASK; address register=0; edge-detect flops=0.
- Edge detect:
  - rx_byte_available goes through 2 sync flops, then an edge register.
  - A byte event is sync==1 with prev==0, i.e. 3 cycles after the input rises.
  - rx_byte is sampled on the byte-event cycle.
- States: IDLE, CMD, READ, WRITE.
  - Any state + transaction_begin -> CMD; tx_byte<=0 in the same cycle.
  - transaction_begin has priority over a simultaneous byte event; that byte is dropped.
  - IDLE: byte events ignored.
  - CMD + byte event:
    - addr<=rx_byte[6:0].
    - rx_byte[7]=0 -> READ; tx_byte<=rd(rx_byte[6:0]) and addr advances, so the data byte after the command returns the start register.
    - rx_byte[7]=1 -> WRITE; tx_byte unchanged.
  - READ + byte event: tx_byte<=rd(addr); addr<=next(addr). Rx data is ignored.
  - WRITE + byte event:
    - If addr<NUM_REGS and RW_MASK[addr]: reg[addr]<=rx_byte and wr_strobe[addr]=1 for one cycle.
    - Otherwise the write is silently dropped.
    - In all cases addr<=next(addr).
  - A transaction ends only by the next transaction_begin (or the timeout); the state is held between bytes.
- rd(a):
  - a==0 -> FPGA_VER.
  - a<NUM_REGS and RW -> reg[a].
  - a<NUM_REGS and RO -> reg_in byte a.
  - a>=NUM_REGS -> 8'h00.
- next(a): a==NUM_REGS-1 -> 0; else a+1 with 7-bit wrap (127->0).
  - Out-of-range start addresses stay out of range until the 7-bit wrap.
- reg_out, wr_strobe and tx_byte are registered outputs; write-to-reg_out latency is 1 cycle after the byte event.
- Reset mid-transaction aborts immediately; registers return to RESET_VAL.

Optional Feature:
- Macro: SPI_REG_BANK_TIMEOUT_EN.
- Defined:
  - A counter runs in CMD/READ/WRITE; it clears on each byte event and on transaction_begin.
  - When it reaches TIMEOUT_CYCLES-1: state<=IDLE, tx_byte<=0, timeout_pulse=1 for one cycle.
  - A write already committed stays committed.
- Undefined:
  - No counter is built; timeout_pulse is tied to 0; the state persists until the next transaction_begin.

Test Plan:
- Version read: begin, bytes 0x00 then 0xFF -> tx_byte=0xC2 after the command byte event; the second slot returns rd(1)=RESET_VAL byte 1 (0x00).
- Burst write: NUM_REGS=8, RW_MASK=8'h06, begin, bytes 0x81,0xA5,0x3C,0x77.
  - Reg1=0xA5 and reg2=0x3C, with wr_strobe[1] and wr_strobe[2] pulsing.
  - Reg3 is read-only, so the 0x77 write is dropped and reg_out byte3 stays 0.
- Wrap read: reg_in byte7=0x5A; begin, bytes 0x07,x,x.
  - Slots return 0x5A, 0xC2, reg1 in order, showing 7->0 wrap.
- Out of range: begin 0x90, 0x11 -> no wr_strobe.
  - Begin 0x10 -> tx_byte=0x00.
- Priority/reset: transaction_begin coincident with a byte event -> state CMD, byte dropped, tx_byte=0.
  - reset_n low mid-WRITE -> reg_out=RESET_VAL and busy=0 asynchronously.
- With SPI_REG_BANK_TIMEOUT_EN, TIMEOUT_CYCLES=100: begin, 0x00, no further bytes -> timeout_pulse at cycle 100, busy=0, tx_byte=0.
  - Without the macro -> busy stays 1 and timeout_pulse stays 0.
